// File: rtl/vc_fifo_pkg.sv
// Constants shared by the VC demux, the per-VC FIFOs and the downstream arbiter.
// Also provides the width helper used to size pointers and occupancy counters.
package vc_fifo_pkg;

  localparam int BW_DEF    = 6;
  localparam int VC_BIT    = 5;
  localparam int DEPTH_DEF = 4;

  // Ceiling log2 that returns at least 1, so a pointer always has a bit.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    if (r == 0) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/vc_fifo_if.sv
// Handshake bundle between one VC demux output, its FIFO and the arbiter.
// The err_clr line exists only when VC_FIFO_ERR_CLR_EN is defined.
interface vc_fifo_if
  import vc_fifo_pkg::*;
#(
  parameter int BW    = BW_DEF,
  parameter int DEPTH = DEPTH_DEF
) ();

  localparam int CW = clog2(DEPTH) + 1;

  logic          push;
  logic [BW-1:0] data_in;
  logic          pop;
  logic [BW-1:0] data_out;
  logic          valid_out;
  logic          full;
  logic          empty;
  logic          almost_full;
  logic          almost_empty;
  logic [CW-1:0] count;
  logic          error;
`ifdef VC_FIFO_ERR_CLR_EN
  logic          err_clr;
`endif

  modport master (
    output push, data_in, pop,
`ifdef VC_FIFO_ERR_CLR_EN
    output err_clr,
`endif
    input  data_out, valid_out, full, empty, almost_full, almost_empty, count, error
  );

  modport slave (
    input  push, data_in, pop,
`ifdef VC_FIFO_ERR_CLR_EN
    input  err_clr,
`endif
    output data_out, valid_out, full, empty, almost_full, almost_empty, count, error
  );

endinterface

// File: rtl/vc_fifo_mem.sv
// DEPTH x BW register file: one synchronous write port, one synchronous read port.
// Only the read register is reset; storage keeps its contents across reset.
module vc_fifo_mem
  import vc_fifo_pkg::*;
#(
  parameter int BW    = BW_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int PW    = clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [PW-1:0] waddr,
  input  logic [BW-1:0] wdata,
  input  logic          re,
  input  logic [PW-1:0] raddr,
  output logic [BW-1:0] rdata
);

  logic [BW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (reset)   rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/vc_fifo.sv
// Per-VC synchronous FIFO with occupancy flags and a sticky overflow/underflow error.
// Define VC_FIFO_ERR_CLR_EN to add an err_clr input that clears the error flag.
module vc_fifo
  import vc_fifo_pkg::*;
#(
  parameter int BW    = BW_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int AF_TH = 3,
  parameter int AE_TH = 1
) (
  input logic     clk,
  input logic     reset,
  vc_fifo_if.slave bus
);

  localparam int PW = clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count_q;
  logic          valid_q;
  logic          error_q;
  logic          full_w;
  logic          empty_w;
  logic          push_acc;
  logic          pop_acc;
  logic          err_evt;
  logic          err_clr_req;

  assign full_w  = (count_q == CW'(DEPTH));
  assign empty_w = (count_q == '0);

  // A full FIFO still takes a write when a read frees a slot in the same cycle.
  always_comb begin
    pop_acc  = 1'b0;
    push_acc = 1'b0;
    err_evt  = 1'b0;
    if (!reset) begin
      pop_acc  = bus.pop && !empty_w;
      push_acc = bus.push && (!full_w || pop_acc);
      err_evt  = (bus.push && full_w && !pop_acc) || (bus.pop && empty_w);
    end
  end

`ifdef VC_FIFO_ERR_CLR_EN
  assign err_clr_req = bus.err_clr;
`else
  assign err_clr_req = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
      error_q <= 1'b0;
    end else begin
      if (push_acc) wr_ptr <= wr_ptr + PW'(1);
      if (pop_acc)  rd_ptr <= rd_ptr + PW'(1);
      case ({push_acc, pop_acc})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
      valid_q <= pop_acc;
      // A fresh error in the same cycle wins over a clear request.
      if (err_evt)          error_q <= 1'b1;
      else if (err_clr_req) error_q <= 1'b0;
    end
  end

  vc_fifo_mem #(
    .BW    (BW),
    .DEPTH (DEPTH),
    .PW    (PW)
  ) u_mem (
    .clk   (clk),
    .reset (reset),
    .we    (push_acc),
    .waddr (wr_ptr),
    .wdata (bus.data_in),
    .re    (pop_acc),
    .raddr (rd_ptr),
    .rdata (bus.data_out)
  );

  assign bus.valid_out    = valid_q;
  assign bus.count        = count_q;
  assign bus.error        = error_q;
  assign bus.full         = full_w;
  assign bus.empty        = empty_w;
  assign bus.almost_full  = (count_q >= CW'(AF_TH));
  assign bus.almost_empty = (count_q <= CW'(AE_TH));

endmodule

// File: tb/tb_vc_fifo.sv
// Directed table-driven bench for vc_fifo (DEPTH=4, AF_TH=3, AE_TH=1), plus
// hand-written reset and empty-corner sequences.
module tb_vc_fifo;
  import vc_fifo_pkg::*;

  logic clk;
  logic reset;

  vc_fifo_if #(.BW(6), .DEPTH(4)) bus ();

  vc_fifo #(.BW(6), .DEPTH(4), .AF_TH(3), .AE_TH(1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // flags packs {full, empty, almost_full, almost_empty}
  typedef struct {
    logic       push;
    logic [5:0] din;
    logic       pop;
    logic [5:0] dout;
    logic       vout;
    logic [2:0] cnt;
    logic [3:0] flags;
    logic       err;
  } vec_t;

  vec_t vecs[$];
  int   tests_run;
  int   tests_failed;

  function automatic vec_t mk(input logic p, input logic [5:0] d, input logic q,
                              input logic [5:0] o, input logic v, input logic [2:0] c,
                              input logic [3:0] f, input logic e);
    vec_t r;
    r.push = p; r.din = d; r.pop = q; r.dout = o;
    r.vout = v; r.cnt = c; r.flags = f; r.err = e;
    return r;
  endfunction

  task automatic check_field(input string label, input string field,
                             input logic [7:0] act, input logic [7:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s %s: got 0x%0h expected 0x%0h", label, field, act, exp);
    end
  endtask

  task automatic check_output(input string label, input vec_t e);
    check_field(label, "data_out",  {2'b00, bus.data_out}, {2'b00, e.dout});
    check_field(label, "valid_out", {7'd0, bus.valid_out}, {7'd0, e.vout});
    check_field(label, "count",     {5'd0, bus.count},     {5'd0, e.cnt});
    check_field(label, "flags",
                {4'd0, bus.full, bus.empty, bus.almost_full, bus.almost_empty},
                {4'd0, e.flags});
    check_field(label, "error",     {7'd0, bus.error},     {7'd0, e.err});
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
  task automatic apply_stimulus(input logic rst, input logic p, input logic [5:0] d,
                                input logic q);
    @(negedge clk);
    reset       = rst;
    bus.push    = p;
    bus.data_in = d;
    bus.pop     = q;
    @(posedge clk);
    #1;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset        = 1'b1;
    bus.push     = 1'b0;
    bus.data_in  = '0;
    bus.pop      = 1'b0;
`ifdef VC_FIFO_ERR_CLR_EN
    bus.err_clr  = 1'b0;
`endif

    apply_stimulus(1, 0, 6'h00, 0);
    apply_stimulus(1, 0, 6'h00, 0);
    check_output("reset", mk(0, 6'h00, 0, 6'h00, 0, 3'd0, 4'b0101, 0));

    // Fill, overflow attempt, drain, then full push+pop with pointer wrap.
    vecs.push_back(mk(0, 6'h00, 0, 6'h00, 0, 3'd0, 4'b0101, 0));
    vecs.push_back(mk(1, 6'h21, 0, 6'h00, 0, 3'd1, 4'b0001, 0));
    vecs.push_back(mk(1, 6'h22, 0, 6'h00, 0, 3'd2, 4'b0000, 0));
    vecs.push_back(mk(1, 6'h23, 0, 6'h00, 0, 3'd3, 4'b0010, 0));
    vecs.push_back(mk(1, 6'h24, 0, 6'h00, 0, 3'd4, 4'b1010, 0));
    vecs.push_back(mk(1, 6'h05, 0, 6'h00, 0, 3'd4, 4'b1010, 1));
    vecs.push_back(mk(0, 6'h00, 1, 6'h21, 1, 3'd3, 4'b0010, 1));
    vecs.push_back(mk(0, 6'h00, 1, 6'h22, 1, 3'd2, 4'b0000, 1));
    vecs.push_back(mk(0, 6'h00, 1, 6'h23, 1, 3'd1, 4'b0001, 1));
    vecs.push_back(mk(0, 6'h00, 1, 6'h24, 1, 3'd0, 4'b0101, 1));
    vecs.push_back(mk(0, 6'h00, 0, 6'h24, 0, 3'd0, 4'b0101, 1));
    vecs.push_back(mk(1, 6'h31, 0, 6'h24, 0, 3'd1, 4'b0001, 1));
    vecs.push_back(mk(1, 6'h32, 0, 6'h24, 0, 3'd2, 4'b0000, 1));
    vecs.push_back(mk(1, 6'h33, 0, 6'h24, 0, 3'd3, 4'b0010, 1));
    vecs.push_back(mk(1, 6'h34, 0, 6'h24, 0, 3'd4, 4'b1010, 1));
    vecs.push_back(mk(1, 6'h06, 1, 6'h31, 1, 3'd4, 4'b1010, 1));
    vecs.push_back(mk(0, 6'h00, 1, 6'h32, 1, 3'd3, 4'b0010, 1));
    vecs.push_back(mk(0, 6'h00, 1, 6'h33, 1, 3'd2, 4'b0000, 1));
    vecs.push_back(mk(0, 6'h00, 1, 6'h34, 1, 3'd1, 4'b0001, 1));
    vecs.push_back(mk(0, 6'h00, 1, 6'h06, 1, 3'd0, 4'b0101, 1));
    vecs.push_back(mk(0, 6'h00, 1, 6'h06, 0, 3'd0, 4'b0101, 1));

    foreach (vecs[i]) begin
      apply_stimulus(0, vecs[i].push, vecs[i].din, vecs[i].pop);
      check_output($sformatf("vec%0d", i), vecs[i]);
    end

    // Empty FIFO with push and pop together: push taken, pop flagged as underflow.
    apply_stimulus(1, 0, 6'h00, 0);
    check_output("rst_a", mk(0, 6'h00, 0, 6'h00, 0, 3'd0, 4'b0101, 0));
    apply_stimulus(0, 1, 6'h11, 1);
    check_output("empty_pushpop", mk(0, 6'h00, 0, 6'h00, 0, 3'd1, 4'b0001, 1));
    apply_stimulus(0, 0, 6'h00, 1);
    check_output("pop_11", mk(0, 6'h00, 0, 6'h11, 1, 3'd0, 4'b0101, 1));

    // Reset mid-stream while pushing: stored words and the pushed word are discarded.
    apply_stimulus(1, 0, 6'h00, 0);
    apply_stimulus(0, 1, 6'h41, 0);
    apply_stimulus(0, 1, 6'h42, 0);
    check_output("fill2", mk(0, 6'h00, 0, 6'h00, 0, 3'd2, 4'b0000, 0));
    apply_stimulus(1, 1, 6'h43, 0);
    check_output("rst_mid", mk(0, 6'h00, 0, 6'h00, 0, 3'd0, 4'b0101, 0));
    apply_stimulus(0, 0, 6'h00, 1);
    check_output("pop_after_rst", mk(0, 6'h00, 0, 6'h00, 0, 3'd0, 4'b0101, 1));
    apply_stimulus(0, 1, 6'h44, 0);
    check_output("push_44", mk(0, 6'h00, 0, 6'h00, 0, 3'd1, 4'b0001, 1));
    apply_stimulus(0, 0, 6'h00, 1);
    check_output("pop_44", mk(0, 6'h00, 0, 6'h44, 1, 3'd0, 4'b0101, 1));

`ifdef VC_FIFO_ERR_CLR_EN
    bus.err_clr = 1'b1;
    apply_stimulus(0, 0, 6'h00, 0);
    check_output("err_clr", mk(0, 6'h00, 0, 6'h44, 0, 3'd0, 4'b0101, 0));
    apply_stimulus(0, 0, 6'h00, 1);
    check_output("err_clr_vs_evt", mk(0, 6'h00, 0, 6'h44, 0, 3'd0, 4'b0101, 1));
    bus.err_clr = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
